// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM (port A write-only, port B read-only)
// with per-lane byte enables, a read-valid flag, selectable read-first or
// write-first collision handling and an optional extra output register.
// Optional feature macro: SDP_RAM_PARITY_EN adds one even-parity bit per
// lane, a PINJ parity-inject hook and the RD_PERR read-side error flag.
module sdp_ram_pipe #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int BYTE_W  = 8,
    parameter int OUT_REG = 0,
    parameter int RW_MODE = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       WEA,
    input  logic [DATA_W/BYTE_W-1:0]   BEA,
    input  logic [ADDR_W-1:0]          ADDRA,
    input  logic [DATA_W-1:0]          DIN,
    input  logic                       PINJ,
    input  logic                       REB,
    input  logic [ADDR_W-1:0]          ADDRB,
    output logic [DATA_W-1:0]          DOUT,
    output logic                       DOUT_VLD,
    output logic                       RD_PERR
);

    localparam int NLANE = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              wr_en;
    logic              rd_en;

    logic              byp_hit;
    logic [NLANE-1:0]  byp_be;
    logic [DATA_W-1:0] byp_data;

    logic              s1_vld;
    logic              s1_loaded;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] s1_data;
    logic              s1_perr;
    logic              perr_out;

    assign wr_en = WEA & RST_N;
    assign rd_en = REB & RST_N;

`ifdef SDP_RAM_PARITY_EN
    logic [NLANE-1:0] pmem [DEPTH];
    logic [NLANE-1:0] rd_par;
    logic [NLANE-1:0] wr_par;
    logic [NLANE-1:0] byp_par;
    logic [NLANE-1:0] merged_par;
    logic [NLANE-1:0] calc_par;

    // Parity generated from write data, optionally inverted for fault injection
    always_comb begin
        wr_par = '0;
        for (int i = 0; i < NLANE; i++) begin
            wr_par[i] = (^DIN[i*BYTE_W +: BYTE_W]) ^ PINJ;
        end
    end
`endif

    // Storage array: no reset so it maps onto block RAM; read-first by nature
    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_word <= mem[ADDRB];
`ifdef SDP_RAM_PARITY_EN
            rd_par  <= pmem[ADDRB];
`endif
        end
        if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (BEA[i]) begin
                    mem[ADDRA][i*BYTE_W +: BYTE_W] <= DIN[i*BYTE_W +: BYTE_W];
`ifdef SDP_RAM_PARITY_EN
                    pmem[ADDRA][i] <= wr_par[i];
`endif
                end
            end
        end
    end

    // Write-first bypass capture; held while idle so DOUT keeps its last value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
`ifdef SDP_RAM_PARITY_EN
            byp_par  <= '0;
`endif
        end else if (REB) begin
            byp_hit  <= (RW_MODE == 1) && WEA && (ADDRA == ADDRB);
            byp_be   <= BEA;
            byp_data <= DIN;
`ifdef SDP_RAM_PARITY_EN
            byp_par  <= wr_par;
`endif
        end
    end

    // First-stage valid; "loaded" forces DOUT to zero until a read after reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_vld    <= 1'b0;
            s1_loaded <= 1'b0;
        end else begin
            s1_vld    <= REB;
            s1_loaded <= s1_loaded | REB;
        end
    end

    // Merge bypassed lanes over the array word on a write-first collision
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NLANE; i++) begin
            if (byp_hit && byp_be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = byp_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign s1_data = s1_loaded ? merged : '0;

`ifdef SDP_RAM_PARITY_EN
    // Recompute parity over the delivered word and compare with stored parity
    always_comb begin
        merged_par = rd_par;
        calc_par   = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (byp_hit && byp_be[i]) begin
                merged_par[i] = byp_par[i];
            end
            calc_par[i] = ^merged[i*BYTE_W +: BYTE_W];
        end
    end

    assign s1_perr = s1_loaded && (calc_par != merged_par);
`else
    logic unused_pinj;
    assign unused_pinj = PINJ;
    assign s1_perr     = 1'b0;
`endif

    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic [DATA_W-1:0] dout_q;
            logic              vld_q;
            logic              perr_q;

            // Second output stage: adds one cycle of latency, holds when idle
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                    perr_q <= 1'b0;
                end else begin
                    vld_q <= s1_vld;
                    if (s1_vld) begin
                        dout_q <= s1_data;
                        perr_q <= s1_perr;
                    end
                end
            end

            assign DOUT     = dout_q;
            assign DOUT_VLD = vld_q;
            assign perr_out = perr_q;
        end else begin : g_no_out_reg
            assign DOUT     = s1_data;
            assign DOUT_VLD = s1_vld;
            assign perr_out = s1_perr;
        end
    endgenerate

    assign RD_PERR = perr_out & DOUT_VLD;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: directed bench driving two instances in lockstep,
// u0 (latency 1, read-first) and u1 (latency 2, write-first).
module tb_sdp_ram_pipe;

    logic        CLK;
    logic        RST_N;
    logic        WEA;
    logic [1:0]  BEA;
    logic [3:0]  ADDRA;
    logic [15:0] DIN;
    logic        PINJ;
    logic        REB;
    logic [3:0]  ADDRB;
    logic [15:0] dout0, dout1;
    logic        vld0, vld1, perr0, perr1;

    int vectors = 0;
    int errors  = 0;

`ifdef SDP_RAM_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    sdp_ram_pipe #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .OUT_REG(0), .RW_MODE(0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .WEA(WEA), .BEA(BEA), .ADDRA(ADDRA), .DIN(DIN),
        .PINJ(PINJ), .REB(REB), .ADDRB(ADDRB),
        .DOUT(dout0), .DOUT_VLD(vld0), .RD_PERR(perr0)
    );

    sdp_ram_pipe #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .OUT_REG(1), .RW_MODE(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .WEA(WEA), .BEA(BEA), .ADDRA(ADDRA), .DIN(DIN),
        .PINJ(PINJ), .REB(REB), .ADDRB(ADDRB),
        .DOUT(dout1), .DOUT_VLD(vld1), .RD_PERR(perr1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, then let one rising edge pass and settle
    task automatic apply_stimulus(input logic we, input logic [1:0] be, input logic [3:0] aa,
                                  input logic [15:0] din, input logic pinj,
                                  input logic re, input logic [3:0] ab);
        WEA   = we;
        BEA   = be;
        ADDRA = aa;
        DIN   = din;
        PINJ  = pinj;
        REB   = re;
        ADDRB = ab;
        @(posedge CLK);
        #1;
    endtask

    // Compare one observed value with its expected value
    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        apply_stimulus(1, 2'b11, 4'd3, 16'hFFFF, 0, 1, 4'd3);
        check_output("rst_dout0", dout0, 16'h0000);
        check_output("rst_vld0",  {15'd0, vld0}, 16'd0);
        check_output("rst_dout1", dout1, 16'h0000);
        check_output("rst_vld1",  {15'd0, vld1}, 16'd0);
        check_output("rst_perr0", {15'd0, perr0}, 16'd0);
        RST_N = 1'b1;
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("post_rst_vld0", {15'd0, vld0}, 16'd0);

        // Contents survive a reset pulse
        apply_stimulus(1, 2'b11, 4'd3, 16'hA5A5, 0, 0, 4'd0);
        RST_N = 1'b0;
        #2;
        check_output("pulse_dout0", dout0, 16'h0000);
        check_output("pulse_vld1",  {15'd0, vld1}, 16'd0);
        RST_N = 1'b1;
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd3);
        check_output("keep_dout0", dout0, 16'hA5A5);
        check_output("keep_vld0",  {15'd0, vld0}, 16'd1);
        check_output("keep_vld1_early", {15'd0, vld1}, 16'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("keep_dout1", dout1, 16'hA5A5);
        check_output("keep_vld1",  {15'd0, vld1}, 16'd1);
        check_output("hold_dout0", dout0, 16'hA5A5);
        check_output("hold_vld0",  {15'd0, vld0}, 16'd0);

        // Byte enables
        apply_stimulus(1, 2'b11, 4'd5, 16'h1234, 0, 0, 4'd0);
        apply_stimulus(1, 2'b01, 4'd5, 16'hFFFF, 0, 0, 4'd0);
        apply_stimulus(1, 2'b00, 4'd5, 16'h0000, 0, 0, 4'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd5);
        check_output("be_dout0", dout0, 16'h12FF);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("be_dout1", dout1, 16'h12FF);

        // Back-to-back latency
        apply_stimulus(1, 2'b11, 4'd0, 16'h1111, 0, 0, 4'd0);
        apply_stimulus(1, 2'b11, 4'd1, 16'h2222, 0, 0, 4'd0);
        apply_stimulus(1, 2'b11, 4'd2, 16'h3333, 0, 0, 4'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd0);
        check_output("lat0_a_dout", dout0, 16'h1111);
        check_output("lat0_a_vld",  {15'd0, vld0}, 16'd1);
        check_output("lat1_a_vld",  {15'd0, vld1}, 16'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd1);
        check_output("lat0_b_dout", dout0, 16'h2222);
        check_output("lat0_b_vld",  {15'd0, vld0}, 16'd1);
        check_output("lat1_b_dout", dout1, 16'h1111);
        check_output("lat1_b_vld",  {15'd0, vld1}, 16'd1);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd2);
        check_output("lat0_c_dout", dout0, 16'h3333);
        check_output("lat0_c_vld",  {15'd0, vld0}, 16'd1);
        check_output("lat1_c_dout", dout1, 16'h2222);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("lat0_d_vld",  {15'd0, vld0}, 16'd0);
        check_output("lat1_d_dout", dout1, 16'h3333);
        check_output("lat1_d_vld",  {15'd0, vld1}, 16'd1);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("lat1_e_vld",  {15'd0, vld1}, 16'd0);

        // Same-address collision, then read at the very next edge
        apply_stimulus(1, 2'b11, 4'd7, 16'h00FF, 0, 0, 4'd0);
        apply_stimulus(1, 2'b10, 4'd7, 16'hAB00, 0, 1, 4'd7);
        check_output("col_rf_dout0", dout0, 16'h00FF);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd7);
        check_output("col_next_dout0", dout0, 16'hABFF);
        check_output("col_wf_dout1",   dout1, 16'hABFF);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("col_next_dout1", dout1, 16'hABFF);
        check_output("col_next_vld1",  {15'd0, vld1}, 16'd1);

        // Reset between issue and delivery drops the in-flight read
        apply_stimulus(1, 2'b11, 4'd8, 16'h5A5A, 0, 0, 4'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd8);
        check_output("wr_rd_dout0", dout0, 16'h5A5A);
        REB = 1'b0;
        #1;
        RST_N = 1'b0;
        #2;
        check_output("mid_vld0",  {15'd0, vld0}, 16'd0);
        check_output("mid_dout0", dout0, 16'h0000);
        RST_N = 1'b1;
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("mid_vld1_a", {15'd0, vld1}, 16'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("mid_vld1_b", {15'd0, vld1}, 16'd0);
        check_output("mid_dout1",  dout1, 16'h0000);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd8);
        check_output("after_dout0", dout0, 16'h5A5A);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("after_dout1", dout1, 16'h5A5A);
        check_output("after_vld1",  {15'd0, vld1}, 16'd1);

        // Parity inject on lane 0, then clean rewrite
        apply_stimulus(1, 2'b11, 4'd9, 16'h0101, 0, 0, 4'd0);
        apply_stimulus(1, 2'b01, 4'd9, 16'h0101, 1, 0, 4'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd9);
        check_output("par_dout0", dout0, 16'h0101);
        check_output("par_err0",  {15'd0, perr0}, {15'd0, PAR_EXP});
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("par_err1",  {15'd0, perr1}, {15'd0, PAR_EXP});
        check_output("par_idle0", {15'd0, perr0}, 16'd0);
        apply_stimulus(1, 2'b01, 4'd9, 16'h0101, 0, 0, 4'd0);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 1, 4'd9);
        check_output("par_ok0", {15'd0, perr0}, 16'd0);
        check_output("par_vld0", {15'd0, vld0}, 16'd1);
        apply_stimulus(0, 2'b00, 4'd0, 16'h0000, 0, 0, 4'd0);
        check_output("par_ok1", {15'd0, perr1}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
